decode_stage: RTL and testbench

Registered RV32I decode stage with a valid/ready handshake on both sides. It sits between fetch and execute. It is the pipelined successor of the combinational instruction decoder. It adds the following:
- Per-format immediate selection to XLEN.
- Illegal-instruction detection.
- Corrected load/store/branch classification.
- An output skid FIFO of parametrised depth, plus flush.

---
 rtl/decode_pkg.sv | 57 +++++
 rtl/decode_comb.sv | 132 +++++++++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// +--------------------------------------------------------------------+
// | decode_pkg : RV32I opcode, size and CSR encodings plus decoded_t   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam logic [1:0] CSR_NONE = 2'd0;
    localparam logic [1:0] CSR_RC   = 2'd1;
    localparam logic [1:0] CSR_RS   = 2'd2;
    localparam logic [1:0] CSR_RW   = 2'd3;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // The immediate is XLEN-wide and travels beside this struct.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
        logic [6:0]  op_code;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [1:0]  mem_read;
        logic        mem_unsigned;
        logic [1:0]  mem_write;
        logic        reg_write;
        logic [1:0]  csr_op;
        logic        csr_imm;
        logic        illegal;
    } decoded_t;

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// +--------------------------------------------------------------------+
// | decode_comb : combinational RV32I/Zicsr field and control decode   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output decoded_t        dec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i_w, imm_s_w, imm_b_w, imm_u_w, imm_j_w, imm32;
    logic        illegal, no_rd;
    logic [1:0]  mem_read, mem_write, csr_op;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign imm_i_w = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_w = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_w = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_w = {instr_i[31:12], 12'b0};
    assign imm_j_w = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        illegal   = 1'b0;
        no_rd     = 1'b0;
        imm32     = 32'h0;
        mem_read  = SZ_NONE;
        mem_write = SZ_NONE;
        csr_op    = CSR_NONE;
        case (opc)
            OPC_LOAD: begin
                imm32 = imm_i_w;
                case (f3)
                    3'b000, 3'b100: mem_read = SZ_BYTE;
                    3'b001, 3'b101: mem_read = SZ_HALF;
                    3'b010:         mem_read = SZ_WORD;
                    default:        illegal  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm32 = imm_s_w;
                no_rd = 1'b1;
                case (f3)
                    3'b000:  mem_write = SZ_BYTE;
                    3'b001:  mem_write = SZ_HALF;
                    3'b010:  mem_write = SZ_WORD;
                    default: illegal   = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                imm32   = imm_b_w;
                no_rd   = 1'b1;
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: imm32 = imm_j_w;
            OPC_JALR: begin
                imm32   = imm_i_w;
                illegal = (f3 != 3'b000);
            end
            OPC_OP: begin
                illegal = !((f7 == F7_ZERO) ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                imm32   = imm_i_w;
                illegal = ((f3 == 3'b001) && (f7 != F7_ZERO)) ||
                          ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT));
            end
            OPC_LUI, OPC_AUIPC: imm32 = imm_u_w;
            OPC_MISC_MEM: no_rd = 1'b1;
            OPC_SYSTEM: begin
                // CSR*I forms carry the 5-bit zimm in the rs1 slot
                imm32 = f3[2] ? {27'b0, instr_i[19:15]} : imm_i_w;
                if (f3 == 3'b100) begin
                    illegal = 1'b1;
                end else if (f3 == 3'b000) begin
                    no_rd   = 1'b1;
                    illegal = (instr_i != INSN_ECALL) && (instr_i != INSN_EBREAK);
                end else begin
                    case (f3[1:0])
                        2'b01:   csr_op = CSR_RW;
                        2'b10:   csr_op = CSR_RS;
                        default: csr_op = CSR_RC;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            mem_read  = SZ_NONE;
            mem_write = SZ_NONE;
            csr_op    = CSR_NONE;
        end
    end

    always_comb begin
        dec_o              = '0;
        dec_o.rs1          = instr_i[19:15];
        dec_o.rs2          = instr_i[24:20];
        dec_o.rd           = instr_i[11:7];
        dec_o.csr_addr     = instr_i[31:20];
        dec_o.op_code      = opc;
        dec_o.func3        = f3;
        dec_o.func7        = f7;
        dec_o.mem_read     = mem_read;
        dec_o.mem_unsigned = (mem_read != SZ_NONE) && f3[2];
        dec_o.mem_write    = mem_write;
        dec_o.reg_write    = !illegal && (instr_i[11:7] != 5'd0) && !no_rd;
        dec_o.csr_op       = csr_op;
        dec_o.csr_imm      = (csr_op != CSR_NONE) && f3[2];
        dec_o.illegal      = illegal;
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +--------------------------------------------------------------------+
// | decode_stage : registered RV32I decode with output skid FIFO/flush |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [11:0]     csr_addr,
    output logic [6:0]      op_code,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      mem_read,
    output logic            mem_unsigned,
    output logic [1:0]      mem_write,
    output logic            reg_write,
    output logic [1:0]      csr_op,
    output logic            csr_imm,
    output logic            illegal
);

    localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
    localparam logic       LAST_PTR = 1'(DEPTH - 1);

    decoded_t        dec_w;
    logic [XLEN-1:0] imm_w;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr_i (instruction),
        .dec_o   (dec_w),
        .imm_o   (imm_w)
    );

    // Storage is sized for the maximum depth; DEPTH=1 never touches entry 1.
    decoded_t        ent_q [2];
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] pc_q  [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q, count_d;
    logic            in_ready_q;
    logic            push_w, pop_w;
    decoded_t        head_w;

    assign push_w = in_valid && in_ready_q && !flush;
    assign pop_w  = (count_q != 2'd0) && out_ready && !flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push_w && !pop_w) begin
            count_d = count_q + 2'd1;
        end else if (!push_w && pop_w) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH_C);
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push_w) begin
                    ent_q[wr_ptr_q] <= dec_w;
                    imm_q[wr_ptr_q] <= imm_w;
                    pc_q[wr_ptr_q]  <= in_pc;
                    wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? 1'b0 : ~wr_ptr_q;
                end
                if (pop_w) begin
                    rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? 1'b0 : ~rd_ptr_q;
                end
            end
        end
    end

    assign head_w       = ent_q[rd_ptr_q];
    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_pc       = pc_q[rd_ptr_q];
    assign imm          = imm_q[rd_ptr_q];
    assign rs1          = head_w.rs1;
    assign rs2          = head_w.rs2;
    assign rd           = head_w.rd;
    assign csr_addr     = head_w.csr_addr;
    assign op_code      = head_w.op_code;
    assign func3        = head_w.func3;
    assign func7        = head_w.func7;
    assign mem_read     = head_w.mem_read;
    assign mem_unsigned = head_w.mem_unsigned;
    assign mem_write    = head_w.mem_write;
    assign reg_write    = head_w.reg_write;
    assign csr_op       = head_w.csr_op;
    assign csr_imm      = head_w.csr_imm;
    assign illegal      = head_w.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// +--------------------------------------------------------------------+
// | tb_decode_stage : directed checks of decode_stage (XLEN 32 and 64) |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage;

    logic        clk, rst_n, in_valid, flush, out_ready;
    logic [31:0] instruction, in_pc;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid, mem_unsigned, reg_write, csr_imm, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr_addr;
    logic [6:0]  op_code, func7;
    logic [2:0]  func3;
    logic [1:0]  mem_read, mem_write, csr_op;

    logic        in_ready_64, out_valid_64, mem_unsigned_64, reg_write_64, csr_imm_64, illegal_64;
    logic [63:0] out_pc_64, imm_64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [11:0] csr_addr_64;
    logic [6:0]  op_code_64, func7_64;
    logic [2:0]  func3_64;
    logic [1:0]  mem_read_64, mem_write_64, csr_op_64;

    int tests_run    = 0;
    int tests_failed = 0;

    assign in_pc64 = {32'h0, in_pc};

    decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .csr_addr(csr_addr), .op_code(op_code),
        .func3(func3), .func7(func7), .imm(imm), .mem_read(mem_read),
        .mem_unsigned(mem_unsigned), .mem_write(mem_write), .reg_write(reg_write),
        .csr_op(csr_op), .csr_imm(csr_imm), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_64),
        .instruction(instruction), .in_pc(in_pc64), .flush(flush),
        .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
        .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .csr_addr(csr_addr_64), .op_code(op_code_64),
        .func3(func3_64), .func7(func7_64), .imm(imm_64), .mem_read(mem_read_64),
        .mem_unsigned(mem_unsigned_64), .mem_write(mem_write_64), .reg_write(reg_write_64),
        .csr_op(csr_op_64), .csr_imm(csr_imm_64), .illegal(illegal_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid    = 1'b1;
        instruction = ins;
        in_pc       = pc;
        step();
        in_valid    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        instruction = 32'h0;
        in_pc       = 32'h0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_imm",       64'(imm),       64'd0);
        check("rst_rd",        64'(rd),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-instruction decode with the consumer always ready
        out_ready = 1'b1;
        issue(32'hFFF0_0093, 32'h0000_0000);
        check("addi_valid",   64'(out_valid), 64'd1);
        check("addi_imm",     64'(imm),       64'hFFFF_FFFF);
        check("addi_rd",      64'(rd),        64'd1);
        check("addi_regw",    64'(reg_write), 64'd1);
        check("addi_illegal", 64'(illegal),   64'd0);

        issue(32'hFE20_AE23, 32'h0000_0004);
        check("sw_memw",   64'(mem_write), 64'd3);
        check("sw_imm",    64'(imm),       64'hFFFF_FFFC);
        check("sw_regw",   64'(reg_write), 64'd0);
        check("sw_rs2",    64'(rs2),       64'd2);

        issue(32'hFE00_0CE3, 32'h0000_0008);
        check("beq_imm",   64'(imm),       64'hFFFF_FFF8);
        check("beq_regw",  64'(reg_write), 64'd0);

        issue(32'h3003_E2F3, 32'h0000_000C);
        check("csrrsi_op",   64'(csr_op),   64'd2);
        check("csrrsi_immf", 64'(csr_imm),  64'd1);
        check("csrrsi_imm",  64'(imm),      64'd7);
        check("csrrsi_addr", 64'(csr_addr), 64'h300);
        check("csrrsi_regw", 64'(reg_write),64'd1);

        issue(32'h0000_0000, 32'h0000_0010);
        check("zero_illegal", 64'(illegal),   64'd1);
        check("zero_regw",    64'(reg_write), 64'd0);

        issue(32'h0081_2183, 32'h0000_0014);
        check("lw_memr",  64'(mem_read),     64'd3);
        check("lw_uns",   64'(mem_unsigned), 64'd0);
        check("lw_imm",   64'(imm),          64'd8);

        issue(32'h0001_4183, 32'h0000_0018);
        check("lbu_memr", 64'(mem_read),     64'd1);
        check("lbu_uns",  64'(mem_unsigned), 64'd1);

        issue(32'h4000_1033, 32'h0000_001C);
        check("op_alt_illegal", 64'(illegal), 64'd1);

        issue(32'h0000_0073, 32'h0000_0020);
        check("ecall_illegal", 64'(illegal),   64'd0);
        check("ecall_regw",    64'(reg_write), 64'd0);
        check("ecall_csr",     64'(csr_op),    64'd0);
        step();
        check("drained_valid", 64'(out_valid), 64'd0);

        // Backpressure: fill both entries, then drain in order
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0010_0093;
        in_pc       = 32'h0000_0100;
        step();
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        instruction = 32'h0020_0113;
        in_pc       = 32'h0000_0104;
        step();
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_head_a",       64'(out_pc),   64'h100);
        instruction = 32'h0030_0193;
        in_pc       = 32'h0000_0108;
        step();
        check("bp_stalled",      64'(in_ready), 64'd0);
        check("bp_head_still_a", 64'(imm),      64'd1);
        out_ready = 1'b1;
        step();
        check("bp_head_b",    64'(out_pc),   64'h104);
        check("bp_imm_b",     64'(imm),      64'd2);
        check("bp_ready_ret", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_head_c",  64'(out_pc),    64'h108);
        check("bp_imm_c",   64'(imm),       64'd3);
        check("bp_valid_c", 64'(out_valid), 64'd1);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with two entries held and a new instruction presented
        out_ready = 1'b0;
        issue(32'h0040_0213, 32'h0000_0200);
        issue(32'h0050_0293, 32'h0000_0204);
        check("fl_full", 64'(in_ready), 64'd0);
        in_valid    = 1'b1;
        instruction = 32'h0060_0313;
        in_pc       = 32'h0000_0208;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        step();
        check("fl_no_ghost", 64'(out_valid), 64'd0);

        // Flush while one entry held and in_ready high: incoming is dropped
        issue(32'h0070_0393, 32'h0000_0300);
        in_valid    = 1'b1;
        instruction = 32'h0080_0413;
        in_pc       = 32'h0000_0304;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 64'(out_valid), 64'd0);
        step();
        check("fl2_dropped", 64'(out_valid), 64'd0);

        // LUI sign extension, then asynchronous reset mid-cycle
        out_ready = 1'b0;
        issue(32'h8000_00B7, 32'h0000_0400);
        check("lui_valid", 64'(out_valid), 64'd1);
        check("lui_imm32", 64'(imm),       64'h8000_0000);
        check("lui_imm64", imm_64,         64'hFFFF_FFFF_8000_0000);
        check("lui_pc64",  out_pc_64,      64'h400);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  64'(out_valid), 64'd0);
        check("arst_imm",    64'(imm),       64'd0);
        check("arst_pc",     64'(out_pc),    64'd0);
        check("arst_rd",     64'(rd),        64'd0);
        check("arst_op",     64'(op_code),   64'd0);
        check("arst_imm64",  imm_64,         64'd0);
        check("arst_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
